// File: rtl/batch_interpolator_pkg.sv
// Shared defaults and sample/batch types for the batch linear interpolator.
// Optional build macro used by the lanes: INTERP_SATURATE_EN (clamp instead of wrap).
package batch_interpolator_pkg;

   localparam int DEF_SAMPLE_WIDTH  = 16;
   localparam int DEF_BATCH_SAMPLES = 16;

   typedef logic signed [DEF_SAMPLE_WIDTH-1:0] sample_t;
   typedef logic [DEF_BATCH_SAMPLES-1:0][DEF_SAMPLE_WIDTH-1:0] batch_t;

endpackage

// File: rtl/batch_interpolator_intrp_lane.sv
// One output lane: computes x + floor(slope * LANE_IDX) over two register stages.
// Macro INTERP_SATURATE_EN clamps the extended sum instead of wrapping it.
module batch_interpolator_intrp_lane
   import batch_interpolator_pkg::*;
#(
   parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
   parameter int BATCH_SIZE   = DEF_BATCH_SAMPLES,
   parameter int LANE_IDX     = 0
) (
   input  logic                            clk,
   input  logic                            rstn,
   input  logic signed [SAMPLE_WIDTH-1:0]   x,
   input  logic signed [2*SAMPLE_WIDTH-1:0] slope,
   output logic [SAMPLE_WIDTH-1:0]          sample
);

   localparam int IDX_WIDTH  = $clog2(BATCH_SIZE);
   localparam int PROD_WIDTH = 2*SAMPLE_WIDTH + IDX_WIDTH;
   localparam logic signed [PROD_WIDTH-1:0] IDX_C = PROD_WIDTH'(LANE_IDX);

   logic signed [SAMPLE_WIDTH-1:0] x_q;
   logic signed [PROD_WIDTH-1:0]   p_d;
   logic signed [PROD_WIDTH-1:0]   p_q;
   logic signed [PROD_WIDTH-1:0]   x_ext;
   logic [SAMPLE_WIDTH-1:0]        sample_d;

   // Constant multiplier: synthesis reduces it to a shift-add tree per lane.
   assign p_d   = PROD_WIDTH'(slope) * IDX_C;
   assign x_ext = PROD_WIDTH'(x_q);

`ifdef INTERP_SATURATE_EN
   localparam logic signed [SAMPLE_WIDTH+1:0] SAT_MAX = (SAMPLE_WIDTH+2)'((1 << (SAMPLE_WIDTH-1)) - 1);
   localparam logic signed [SAMPLE_WIDTH+1:0] SAT_MIN = -(SAMPLE_WIDTH+2)'(1 << (SAMPLE_WIDTH-1));

   logic signed [SAMPLE_WIDTH+1:0] sum;

   assign sum = (SAMPLE_WIDTH+2)'(x_ext + (p_q >>> SAMPLE_WIDTH));

   always_comb begin
      sample_d = SAMPLE_WIDTH'(sum);
      if (sum > SAT_MAX) begin
         sample_d = SAMPLE_WIDTH'(SAT_MAX);
      end else if (sum < SAT_MIN) begin
         sample_d = SAMPLE_WIDTH'(SAT_MIN);
      end
   end
`else
   // Arithmetic shift floors the fraction; truncation to the sample width wraps.
   assign sample_d = SAMPLE_WIDTH'(x_ext + (p_q >>> SAMPLE_WIDTH));
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         x_q    <= '0;
         p_q    <= '0;
         sample <= '0;
      end else begin
         x_q    <= x;
         p_q    <= p_d;
         sample <= sample_d;
      end
   end

endmodule

// File: rtl/batch_interpolator.sv
// Expands one (x, slope) point into a full batch of BATCH_SIZE linearly spaced samples,
// two-cycle latency, one batch per clock. Build macro: INTERP_SATURATE_EN.
module batch_interpolator
   import batch_interpolator_pkg::*;
#(
   parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
   parameter int BATCH_SIZE   = DEF_BATCH_SAMPLES   // >= 2, power of two
) (
   input  logic                                 clk,
   input  logic                                 rstn,
   input  logic [SAMPLE_WIDTH-1:0]              x,
   input  logic [2*SAMPLE_WIDTH-1:0]            slope,
   output logic [BATCH_SIZE*SAMPLE_WIDTH-1:0]   intrp_batch
);

   // Each lane owns its slice of the output bus, element 0 in the LSBs.
   for (genvar i = 0; i < BATCH_SIZE; i++) begin : g_lane
      batch_interpolator_intrp_lane #(
         .SAMPLE_WIDTH (SAMPLE_WIDTH),
         .BATCH_SIZE   (BATCH_SIZE),
         .LANE_IDX     (i)
      ) u_lane (
         .clk    (clk),
         .rstn   (rstn),
         .x      (x),
         .slope  (slope),
         .sample (intrp_batch[i*SAMPLE_WIDTH +: SAMPLE_WIDTH])
      );
   end

endmodule

// File: tb/tb_batch_interpolator.sv
// Self-checking bench for batch_interpolator: reference model feeds an expected queue,
// a negedge monitor pops and compares. Honours INTERP_SATURATE_EN like the design.
module tb_batch_interpolator;
   import batch_interpolator_pkg::*;

   localparam int SW = DEF_SAMPLE_WIDTH;
   localparam int BS = DEF_BATCH_SAMPLES;
   localparam int BW = SW * BS;

   logic          clk;
   logic          rstn;
   logic [SW-1:0]   x;
   logic [2*SW-1:0] slope;
   logic [BW-1:0]   intrp_batch;

   logic [BW-1:0] exp_q[$];
   logic          drv_vld;
   logic [1:0]    vld_pipe;
   int            n_checks;
   int            n_errors;

   batch_interpolator #(
      .SAMPLE_WIDTH (SW),
      .BATCH_SIZE   (BS)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .x           (x),
      .slope       (slope),
      .intrp_batch (intrp_batch)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Two-cycle latency tracker for which output cycles carry a scoreboarded batch.
   always @(posedge clk or negedge rstn) begin
      if (!rstn) vld_pipe <= 2'b00;
      else       vld_pipe <= {vld_pipe[0], drv_vld};
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic batch_t model(input logic [SW-1:0] xv, input logic [2*SW-1:0] sv);
      batch_t b;
      longint prod;
      longint sum;
      for (int i = 0; i < BS; i++) begin
         prod = longint'($signed(sv)) * i;
         sum  = longint'($signed(xv)) + (prod >>> SW);
`ifdef INTERP_SATURATE_EN
         if (sum >  32767) sum =  32767;
         if (sum < -32768) sum = -32768;
`endif
         b[i] = sum[SW-1:0];
      end
      return b;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic apply(input logic [SW-1:0] xv, input logic [2*SW-1:0] sv);
      @(negedge clk);
      x       = xv;
      slope   = sv;
      drv_vld = 1'b1;
      exp_q.push_back(model(xv, sv));
   endtask

   task automatic idle();
      @(negedge clk);
      drv_vld = 1'b0;
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (vld_pipe[1]) begin
         if (exp_q.size() == 0) check("underflow", intrp_batch, '1);
         else                   check("batch", intrp_batch, exp_q.pop_front());
      end
   end

   // ---------------- stimulus ----------------
   logic [SW-1:0]   dir_x[7]     = '{16'd100, 16'd100, 16'd0, 16'h7FFE, 16'd10, 16'd20, 16'd30};
   logic [2*SW-1:0] dir_slope[7] = '{32'h0001_0000, 32'h0000_8000, 32'hFFFF_0000, 32'h0001_0000,
                                     32'h0001_0000, 32'h0002_0000, 32'h0000_0000};

   initial begin
      logic [15:0]     s_int;
      logic [2*SW-1:0] rs;
      n_checks = 0;
      n_errors = 0;
      rstn     = 1'b0;
      x        = '0;
      slope    = '0;
      drv_vld  = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_state", intrp_batch, '0);
      rstn = 1'b1;

      // Directed points; the last three are back-to-back on consecutive cycles.
      for (int k = 0; k < 4; k++) apply(dir_x[k], dir_slope[k]);
      repeat (3) idle();
      for (int k = 4; k < 7; k++) apply(dir_x[k], dir_slope[k]);
      repeat (3) idle();

      // Random points with bounded integer slope, occasional bubbles.
      for (int k = 0; k < 24; k++) begin
         s_int = 16'($urandom_range(0, 4000) - 2000);
         rs    = {s_int, 16'($urandom_range(0, 16'hFFFF))};
         apply(16'($urandom_range(0, 16'hFFFF)), rs);
         if ($urandom_range(0, 3) == 0) idle();
      end

      // Asynchronous reset pulse while batches are in flight.
      apply(16'd1000, 32'h0003_0000);
      apply(16'd2000, 32'hFFFE_0000);
      @(posedge clk);
      #3;
      rstn = 1'b0;
      drv_vld = 1'b0;
      #1;
      check("rst_async_clear", intrp_batch, '0);
      exp_q.delete();
      @(negedge clk);
      check("rst_hold", intrp_batch, '0);
      @(negedge clk);
      rstn    = 1'b1;
      x       = 16'd55;
      slope   = 32'h0001_0000;
      drv_vld = 1'b1;
      exp_q.push_back(model(16'd55, 32'h0001_0000));
      @(negedge clk);
      drv_vld = 1'b0;
      check("rst_refill_zero", intrp_batch, '0);
      repeat (2) idle();

      // Drain with a bounded wait.
      for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
      check("drain", BW'(exp_q.size()), '0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/batch_interpolator.md
Name:
batch_interpolator

Overview:
- Combinational-plus-pipeline linear interpolator in the DAC clock domain.
- Given a start sample x and a fixed-point slope, it produces one full batch of BATCH_SIZE samples each cycle, where sample i = x + slope*i.
- The PWL waveform generator uses it to expand one (x, slope) segment point into a parallel DAC batch.
- Fully pipelined: one new batch per clock, fixed latency.

Parameters:
- SAMPLE_WIDTH, 16, bits per output sample (two's complement).
- BATCH_SIZE, 16, samples per output batch; must be ≥ 2 and a power of two.

Ports:
- clk  input  1  DAC clock; all logic on rising edge.
- rstn  input  1  asynchronous active-low reset.
- x  input  SAMPLE_WIDTH  signed start sample; this is the batch sample 0 value.
- slope  input  2*SAMPLE_WIDTH  signed fixed-point per-sample increment:
  - upper SAMPLE_WIDTH bits are the integer part;
  - lower SAMPLE_WIDTH bits are the fraction.
- intrp_batch  output  BATCH_SIZE*SAMPLE_WIDTH  packed batch; element i is bits [i*SAMPLE_WIDTH +: SAMPLE_WIDTH]; element 0 is the LSBs.

Behaviour:
- Reset:
  - rstn low asynchronously clears all pipeline registers and intrp_batch to 0.
  - The first post-reset outputs appear 2 cycles after the first clocked inputs.
- Pipeline, latency exactly 2 clk cycles, throughput 1 batch per cycle, no stall or handshake:
  - Stage 1 registers x and products p_i = slope * i for i = 0..BATCH_SIZE-1.
  - Products are signed, width 2*SAMPLE_WIDTH + clog2(BATCH_SIZE).
  - Stage 2 registers intrp_batch[i] = x + (p_i >>> SAMPLE_WIDTH).
- Arithmetic rules:
  - The shift is arithmetic, so the fraction truncates toward negative infinity (floor). There is no rounding.
  - The sum is formed at SAMPLE_WIDTH+2 bits signed.
  - Default: the result wraps modulo 2^SAMPLE_WIDTH, i.e. the low SAMPLE_WIDTH bits are kept.
  - Element 0 always equals the registered x.
- Products use constant multipliers (shift-add is acceptable); no DSP sharing across cycles.
- Inputs are sampled every cycle. Changing inputs on consecutive cycles yields the corresponding batches on consecutive cycles.
- Reset mid-stream:
  - Output clears immediately.
  - In-flight batches are discarded.
  - Stage contents are 0 until refilled.

Optional Feature:
- Macro INTERP_SATURATE_EN.
- When defined:
  - Each element's extended sum is clamped to [-2^(SAMPLE_WIDTH-1), 2^(SAMPLE_WIDTH-1)-1] instead of wrapping.
  - Latency is unchanged.
- When undefined: plain modulo wrap.

Decomposition:
- Shared package provides:
  - the SAMPLE_WIDTH and BATCH_SAMPLES defaults;
  - a typedef for one sample;
  - a typedef for a packed batch array.
- One natural sub-module is intrp_lane: a single-sample lane (constant index i, multiply, shift, add, optional saturate, 2 registers), instantiated BATCH_SIZE times by generate.

Test Plan:
All scenarios use SAMPLE_WIDTH=16, BATCH_SIZE=16.
- x=100, slope=0x0001_0000 (1.0) -> 2 cycles later the batch is 100,101,…,115.
- x=100, slope=0x0000_8000 (0.5) -> 100,100,101,101,…,107,107.
- x=0, slope=0xFFFF_0000 (-1.0) -> 0x0000,0xFFFF,0xFFFE,…,0xFFF1.
- x=0x7FFE, slope=0x0001_0000:
  - without the macro -> elements 0..2 = 0x7FFE,0x7FFF,0x8000 (wrap);
  - with INTERP_SATURATE_EN -> elements 0..2 = 0x7FFE,0x7FFF,0x7FFF, and the remaining elements stay 0x7FFF.
- Back-to-back: apply (10,1.0), (20,2.0), (30,0) on 3 consecutive cycles -> outputs on 3 consecutive cycles, 2 cycles delayed:
  - 10..25;
  - 20,22,…,50;
  - all 30.
- Pulse rstn low asynchronously mid-stream -> intrp_batch reads 0 before the next clock edge and stays 0 until 2 cycles after reset release.
